data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
Multi-cycle data-memory responder at the far end of the control unit's 3-bit memory-op code (MemWrite). It accepts load/store requests from the datapath, stalls the core for a fixed, parameterised wait-state count, and performs the access. It then returns load data that is byte-selected and sign- or zero-extended, and flags misaligned or illegal ops. It sits between the ALU result / rs2 read port and the ResultSrc mux, replacing the zero-latency data RAM.

Parameters:
ADDR_WIDTH, 17, byte-address bits used (memory depth = 2^(ADDR_WIDTH-2) words); upper address bits are ignored, so addresses wrap.
LATENCY, 2, wait-state cycles per access (legal range 1..15).
INIT_FILE, "", hex file loaded into the array at elaboration; empty string means no preload.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mem_read  in  1  load request (driven by ResultSrc==2'b01)
mem_ctrl  in  3  op code: bit0=write, bit1=byte, bit2=unsigned. 000 lw/idle, 001 sw, 010 lb, 011 sb, 110 lbu
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  hold PC and pipeline
resp_valid  out  1  access complete; rdata/err valid this cycle
rdata  out  32  extended load result
err  out  1  misaligned or illegal access

Behaviour:
- Single clock domain, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE, cnt=0, stall=0, resp_valid=0, rdata=0, err=0. Memory contents are not cleared.
- Request: req = mem_read | mem_ctrl[0], sampled only in IDLE.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req: stall=1 combinationally in the same cycle.
  - Latch op, addr, wdata and the decoded mem_read; load cnt=LATENCY-1; go to BUSY.
  - If no req: stall=0.
- BUSY:
  - stall=1.
  - If cnt!=0: decrement cnt.
  - If cnt==0: perform the access at this edge and go to RESP.
- RESP:
  - stall=0, resp_valid=1; rdata and err are registered values.
  - Next state is always IDLE.
  - A req seen during RESP is ignored; the core advances at the end of RESP.
- Timing for a request in cycle 0: stall is high in cycles 0..LATENCY, and resp_valid pulses in cycle LATENCY+1. With LATENCY=2, the response arrives in cycle 3.
- Memory layout: word array, little-endian; index = addr[ADDR_WIDTH-1:2]; byte lane = addr[1:0].
- Stores:
  - sw writes the full word.
  - sb writes only lane addr[1:0] with wdata[7:0]; the other lanes are untouched.
- Loads:
  - lw returns the word.
  - lb sign-extends the selected byte.
  - lbu zero-extends the selected byte.
- Error cases (any of these gives no memory write, rdata=0, err=1, and still completes via RESP):
  - Misaligned: lw or sw with addr[1:0]!=0.
  - Illegal op: code 100, 101 or 111.
  - Conflict: mem_read=1 together with mem_ctrl[0]=1.
- Store response: rdata=0, err=0.
- Reset mid-operation (rst in BUSY or RESP): return to IDLE next edge. The pending access is dropped, with no write committed. All outputs are 0 the cycle after.
- Back-to-back: each access costs LATENCY+2 cycles; there is no overlap or pipelining of requests.
- Counter width: 4 bits.

Decomposition:
- Package mem_pkg:
  - localparams for the op codes: MEM_LW=3'b000, MEM_SW=3'b001, MEM_LB=3'b010, MEM_SB=3'b011, MEM_LBU=3'b110.
  - typedef enum logic [1:0] mem_state_t {IDLE, BUSY, RESP}.
- Sub-module load_extend: combinational (word, lane, op) -> 32-bit extended result. It is reused by any later cache.
- The FSM, counter and array live in data_mem_unit.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then mem_read=0, mem_ctrl=000 -> stall=0, resp_valid=0, rdata=0 for 10 cycles.
- Store then load word (LATENCY=2): sw addr=0x100, wdata=0xDEADBEEF -> stall high in cycles 0-2, resp_valid in cycle 3. Then lw 0x100 -> rdata=0xDEADBEEF, err=0.
- Byte ops: sb addr=0x102, wdata=0x000000F0 over word 0x11223344. lw 0x100 -> 0x11F03344. lb 0x102 -> 0xFFFFFFF0. lbu 0x102 -> 0x000000F0.
- Misaligned and illegal: lw 0x101 -> err=1, rdata=0. sw 0x103 -> word at 0x100 unchanged. mem_ctrl=111 -> err=1.
- Reset mid-access: sw 0x200 = 0xCAFEF00D with rst asserted in the first BUSY cycle -> no resp_valid. Later lw 0x200 returns the prior contents (0).
- Address wrap: with ADDR_WIDTH=17, sw at 0x00020040 = 0x5A5A5A5A, then lw 0x40 -> 0x5A5A5A5A.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared op codes and FSM state type for the multi-cycle data memory.
package mem_pkg;

  localparam logic [2:0] MEM_LW  = 3'b000;
  localparam logic [2:0] MEM_SW  = 3'b001;
  localparam logic [2:0] MEM_LB  = 3'b010;
  localparam logic [2:0] MEM_SB  = 3'b011;
  localparam logic [2:0] MEM_LBU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } mem_state_t;

endpackage

// File: rtl/load_extend.sv
// Picks a byte lane out of a little-endian word and sign/zero-extends it for
// byte loads; word loads pass through untouched.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] result
);

  logic [7:0] sel;

  // lane select followed by op-dependent extension
  always_comb begin
    sel    = 8'h00;
    result = word;
    case (lane)
      2'd0:    sel = word[7:0];
      2'd1:    sel = word[15:8];
      2'd2:    sel = word[23:16];
      2'd3:    sel = word[31:24];
      default: sel = 8'h00;
    endcase
    case (op)
      MEM_LB:  result = {{24{sel[7]}}, sel};
      MEM_LBU: result = {24'h000000, sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Multi-cycle data memory: latches a load/store, waits LATENCY cycles while
// stalling the core, then performs the access and returns one response pulse.
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int    ADDR_WIDTH = 17,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic [2:0]  mem_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << IDX_W;

  logic [31:0]           mem [DEPTH];
  mem_state_t            state;
  logic [3:0]            cnt;
  logic [2:0]            lat_op;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic                  lat_rd;
  logic                  req;
  logic                  access;
  logic                  bad_op;
  logic                  misaligned;
  logic                  acc_err;
  logic                  wr_en;
  logic [IDX_W-1:0]      idx;
  logic [1:0]            lane;
  logic [31:0]           cur_word;
  logic [31:0]           ext_word;
  logic                  unused_addr;

  // Upper address bits are dropped on purpose so addresses wrap.
  assign unused_addr = ^addr[31:ADDR_WIDTH];

  assign req      = mem_read | mem_ctrl[0];
  assign idx      = lat_addr[ADDR_WIDTH-1:2];
  assign lane     = lat_addr[1:0];
  assign cur_word = mem[idx];
  assign acc_err  = bad_op | misaligned | (lat_rd & lat_op[0]);
  assign access   = (state == BUSY) && (cnt == 4'd0) && !rst;
  assign wr_en    = access & ~acc_err & lat_op[0];

  load_extend u_load_extend (
    .word   (cur_word),
    .lane   (lane),
    .op     (lat_op),
    .result (ext_word)
  );

  // classify the latched request
  always_comb begin
    bad_op     = 1'b0;
    misaligned = 1'b0;
    case (lat_op)
      MEM_LW, MEM_SW:          misaligned = (lane != 2'b00);
      MEM_LB, MEM_SB, MEM_LBU: misaligned = 1'b0;
      default:                 bad_op = 1'b1;
    endcase
  end

  // stall rises in the request cycle itself so the PC never advances past it
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = req;
      BUSY:    stall = 1'b1;
      RESP:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // memory write port: full word or a single byte lane
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (lat_op == MEM_SW) begin
        mem[idx] <= lat_wdata;
      end else begin
        mem[idx][{lane, 3'b000} +: 8] <= lat_wdata[7:0];
      end
    end
  end

  // request sequencer with registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat_op     <= 3'b000;
      lat_addr   <= '0;
      lat_wdata  <= 32'h0;
      lat_rd     <= 1'b0;
      resp_valid <= 1'b0;
      rdata      <= 32'h0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          rdata      <= 32'h0;
          err        <= 1'b0;
          if (req) begin
            lat_op    <= mem_ctrl;
            lat_addr  <= addr[ADDR_WIDTH-1:0];
            lat_wdata <= wdata;
            lat_rd    <= mem_read;
            cnt       <= 4'(LATENCY - 1);
            state     <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            err        <= acc_err;
            rdata      <= (acc_err | lat_op[0]) ? 32'h0 : ext_word;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          rdata      <= 32'h0;
          err        <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_unit.sv
// Randomised and directed bench for data_mem_unit against a word-map reference model.
module tb_data_mem_unit;

  localparam int LAT = 2;
  localparam int RESP_CYC = LAT + 1;
  localparam logic [15:0] STALL_MASK = 16'((1 << (LAT + 1)) - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic [2:0]  mem_ctrl = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [31:0] model [int];
  logic [15:0] o_st;
  int          o_rc;
  logic [31:0] o_rdata, x_rdata;
  logic        o_err, x_err;

  data_mem_unit #(.ADDR_WIDTH(17), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_ctrl(mem_ctrl),
    .addr(addr), .wdata(wdata), .stall(stall), .resp_valid(resp_valid),
    .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: memory as a map of words, results derived from the op rules.
  task automatic model_op(input logic rd, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] er, output logic ee);
    int idx, lane;
    logic [31:0] w, b;
    idx  = int'(a % 32'h20000) / 4;
    lane = int'(a % 32'd4);
    w    = model.exists(idx) ? model[idx] : 32'h0;
    ee   = (rd && c[0]) || c == 3'b100 || c == 3'b101 || c == 3'b111 ||
           ((c == 3'b000 || c == 3'b001) && lane != 0);
    er   = 32'h0;
    if (!ee) begin
      if (c == 3'b001) model[idx] = wd;
      else if (c == 3'b011) model[idx] = (w & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
      else begin
        b = (w >> (8 * lane)) & 32'hFF;
        if (c == 3'b000) er = w;
        else if (c == 3'b010 && b >= 32'd128) er = b | 32'hFFFFFF00;
        else er = b;
      end
    end
  endtask

  // Drives one request and records stall per cycle and the response, bounded to 20 cycles.
  task automatic access(input logic rd, input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_read = rd; mem_ctrl = c; addr = a; wdata = wd;
    o_st = 16'h0; o_rc = 99; o_rdata = 32'h0; o_err = 1'b0;
    #1 o_st[0] = stall;
    for (int cyc = 1; cyc < 20; cyc++) begin
      @(negedge clk);
      mem_read = 1'b0; mem_ctrl = 3'b000;
      #1;
      if (cyc < 16) o_st[cyc] = stall;
      if (resp_valid) begin
        o_rc = cyc; o_rdata = rdata; o_err = err;
        break;
      end
    end
  endtask

  task automatic run(input logic rd, input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd);
    model_op(rd, c, a, wd, x_rdata, x_err);
    access(rd, c, a, wd);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if ({stall, resp_valid, rdata, err} !== 35'h0) begin
        failures++;
        $display("FAIL reset_idle cyc %0d: stall=%b valid=%b rdata=%h err=%b want all 0", i, stall, resp_valid, rdata, err);
      end
    end
  endtask

  task automatic test_word;
    run(1'b0, 3'b001, 32'h100, 32'hDEADBEEF);
    checks++;
    if (o_st !== STALL_MASK) begin failures++; $display("FAIL sw_stall: got %h want %h", o_st, STALL_MASK); end
    checks++;
    if (o_rc !== RESP_CYC) begin failures++; $display("FAIL sw_resp_cycle: got %0d want %0d", o_rc, RESP_CYC); end
    checks++;
    if ({o_rdata, o_err} !== 33'h0) begin failures++; $display("FAIL sw_resp: rdata=%h err=%b want 0/0", o_rdata, o_err); end
    run(1'b1, 3'b000, 32'h100, 32'h0);
    checks++;
    if (o_rdata !== 32'hDEADBEEF || o_err !== 1'b0 || o_rc !== RESP_CYC) begin
      failures++; $display("FAIL lw_word: rdata=%h err=%b cyc=%0d want DEADBEEF/0/%0d", o_rdata, o_err, o_rc, RESP_CYC);
    end
  endtask

  task automatic test_bytes;
    run(1'b0, 3'b001, 32'h100, 32'h11223344);
    run(1'b0, 3'b011, 32'h102, 32'h000000F0);
    run(1'b1, 3'b000, 32'h100, 32'h0);
    checks++;
    if (o_rdata !== 32'h11F03344) begin failures++; $display("FAIL sb_merge: got %h want 11F03344", o_rdata); end
    run(1'b1, 3'b010, 32'h102, 32'h0);
    checks++;
    if (o_rdata !== 32'hFFFFFFF0 || o_err !== 1'b0) begin failures++; $display("FAIL lb_sign: got %h err=%b want FFFFFFF0/0", o_rdata, o_err); end
    run(1'b1, 3'b110, 32'h102, 32'h0);
    checks++;
    if (o_rdata !== 32'h000000F0 || o_err !== 1'b0) begin failures++; $display("FAIL lbu_zero: got %h err=%b want 000000F0/0", o_rdata, o_err); end
  endtask

  task automatic test_errors;
    run(1'b1, 3'b000, 32'h101, 32'h0);
    checks++;
    if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_rc !== RESP_CYC) begin failures++; $display("FAIL lw_misaligned: err=%b rdata=%h cyc=%0d want 1/0/%0d", o_err, o_rdata, o_rc, RESP_CYC); end
    run(1'b0, 3'b001, 32'h103, 32'hFFFFFFFF);
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL sw_misaligned: err=%b want 1", o_err); end
    run(1'b0, 3'b111, 32'h100, 32'h0);
    checks++;
    if (o_err !== 1'b1 || o_rdata !== 32'h0) begin failures++; $display("FAIL illegal_111: err=%b rdata=%h want 1/0", o_err, o_rdata); end
    run(1'b1, 3'b011, 32'h100, 32'h000000AA);
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL conflict: err=%b want 1", o_err); end
    run(1'b1, 3'b100, 32'h100, 32'h0);
    checks++;
    if (o_err !== 1'b1) begin failures++; $display("FAIL illegal_100: err=%b want 1", o_err); end
    run(1'b1, 3'b000, 32'h100, 32'h0);
    checks++;
    if (o_rdata !== 32'h11F03344) begin failures++; $display("FAIL err_no_write: got %h want 11F03344", o_rdata); end
  endtask

  task automatic test_reset_mid;
    int seen;
    run(1'b0, 3'b001, 32'h200, 32'h0);
    @(negedge clk);
    mem_read = 1'b0; mem_ctrl = 3'b001; addr = 32'h200; wdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_ctrl = 3'b000; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({stall, resp_valid, rdata, err} !== 35'h0) begin failures++; $display("FAIL mid_reset_outputs: stall=%b valid=%b rdata=%h err=%b want all 0", stall, resp_valid, rdata, err); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL mid_reset_no_resp: got %0d responses want 0", seen); end
    run(1'b1, 3'b000, 32'h200, 32'h0);
    checks++;
    if (o_rdata !== 32'h0 || o_err !== 1'b0) begin failures++; $display("FAIL mid_reset_dropped: got %h want 00000000", o_rdata); end
  endtask

  task automatic test_wrap;
    run(1'b0, 3'b001, 32'h00020040, 32'h5A5A5A5A);
    run(1'b1, 3'b000, 32'h00000040, 32'h0);
    checks++;
    if (o_rdata !== 32'h5A5A5A5A) begin failures++; $display("FAIL addr_wrap: got %h want 5A5A5A5A", o_rdata); end
  endtask

  task automatic test_back_to_back;
    run(1'b0, 3'b001, 32'h180, 32'h01020304);
    checks++;
    if (o_rc !== RESP_CYC) begin failures++; $display("FAIL b2b_first: cyc=%0d want %0d", o_rc, RESP_CYC); end
    run(1'b1, 3'b010, 32'h183, 32'h0);
    checks++;
    if (o_st !== STALL_MASK || o_rc !== RESP_CYC || o_rdata !== 32'h00000001) begin
      failures++; $display("FAIL b2b_second: stall=%h cyc=%0d rdata=%h want %h/%0d/00000001", o_st, o_rc, o_rdata, STALL_MASK, RESP_CYC);
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [2:0]  c;
    logic        rd;
    for (int k = 0; k < 8; k++) run(1'b0, 3'b001, 32'h300 + 32'(4 * k), $urandom);
    for (int n = 0; n < 48; n++) begin
      a = (32'($urandom_range(0, 3)) << 17) | 32'h300 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin rd = 1'b1; c = 3'b000; end
        1: begin rd = 1'b0; c = 3'b001; end
        2: begin rd = 1'b1; c = 3'b010; end
        3: begin rd = 1'b0; c = 3'b011; end
        4: begin rd = 1'b1; c = 3'b110; end
        5: begin c = ($urandom_range(0, 1) == 0) ? 3'b101 : 3'b111; rd = 1'($urandom_range(0, 1)); end
        6: begin rd = 1'b1; c = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b011; end
        default: begin rd = 1'b1; c = 3'b000; a[1:0] = 2'b00; end
      endcase
      run(rd, c, a, $urandom);
      checks++;
      if (o_rc !== RESP_CYC || o_st !== STALL_MASK || o_rdata !== x_rdata || o_err !== x_err) begin
        failures++;
        $display("FAIL random_%0d rd=%b op=%b addr=%h: rdata=%h err=%b cyc=%0d stall=%h want %h/%b/%0d/%h",
                 n, rd, c, a, o_rdata, o_err, o_rc, o_st, x_rdata, x_err, RESP_CYC, STALL_MASK);
      end
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_bytes;
    test_errors;
    test_reset_mid;
    test_wrap;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
